// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: push/pop/tos strobes, registered
// top-of-stack output, occupancy status and sticky overflow/underflow flags.
module stack_unit #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_addr;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  // Only meaningful when not empty; every use below is guarded by !is_empty.
  assign top_addr = AW'(count_q - CW'(1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_addr     = count_q[AW-1:0];

    // tos samples the pre-edge top, so same-cycle din is never forwarded.
    if (tos) begin
      if (is_empty) underflow_d = 1'b1;
      else          dout_d      = mem_q[top_addr];
    end

    if (push && pop) begin
      if (is_empty) begin
        wr_en       = 1'b1;
        wr_addr     = '0;
        count_d     = CW'(1);
        underflow_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_addr = top_addr;
      end
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (is_empty) underflow_d = 1'b1;
      else          count_d     = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone defines
  // which entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= din;
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack for the multicycle stack CPU.
- Responds to the controller's one-cycle command strobes: push, pop and tos (read top of stack).
- Returns the top-of-stack value in a registered output for the A/B operand registers. Takes push data from memory read data or the ALU result, selected upstream.
- Reports empty/full/occupancy and sticky overflow/underflow error flags.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 8, number of stack entries (power of two, >= 2)
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
push  input  1  push din onto stack this cycle
pop  input  1  remove top entry this cycle
tos  input  1  capture current top entry into dout
din  input  WIDTH  data to push
dout  output  WIDTH  registered top-of-stack read data
count  output  CW  number of valid entries, 0..DEPTH
empty  output  1  count == 0 (combinational from count)
full  output  1  count == DEPTH (combinational from count)
overflow  output  1  sticky: push attempted while full without pop
underflow  output  1  sticky: pop or tos attempted while empty

Behaviour:
- Reset (async, rst=1):
  - count=0, dout=0, overflow=0, underflow=0, so empty=1 and full=0.
  - Storage array contents are not reset.
  - Reset mid-operation aborts any command in that cycle. The first edge after rst deasserts behaves as on an empty stack.
- Storage:
  - Register array mem[0..DEPTH-1].
  - Top entry is mem[count-1]. Writes go to mem[count] on push.
- All commands are sampled on the rising clk edge. Effects are visible the next cycle, so latency is 1 cycle for dout and count.
- tos alone, not empty: dout <= mem[count-1]. count unchanged.
- push alone:
  - Not full: mem[count] <= din, count <= count+1.
  - Full: no write, count unchanged, overflow <= 1.
- pop alone:
  - Not empty: count <= count-1. dout unchanged unless tos is also set. Pop does not write memory.
  - Empty: count unchanged, underflow <= 1.
- tos+pop, not empty (controller operand fetch): dout <= mem[count-1] (pre-pop top), then count <= count-1 in the same edge.
- push+pop, not empty (replace top): mem[count-1] <= din, count unchanged, no overflow even when full.
- push+pop, empty: push only (mem[0] <= din, count <= 1), and underflow <= 1.
- tos with push (with or without pop): dout gets the pre-write top. Same-cycle din is never forwarded to dout.
- tos while empty: dout unchanged, underflow <= 1. Any pop/push in that cycle follows the rules above.
- Error flags:
  - overflow and underflow are sticky until rst. Neither flag blocks further operation.
  - Ignored commands never corrupt count or memory.
- Pointer arithmetic: count never wraps. It saturates at 0 and DEPTH by the ignore rules above. No modulo addressing.
- No state machine beyond the count register. All command combinations are legal and fully decoded per the priority above: push/pop resolution, then tos capture using pre-edge state.

Test Plan:
- Reset then idle (WIDTH=8, DEPTH=4) -> count=0, empty=1, full=0, dout=0, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then tos -> count=3 and dout=0x33 one cycle after tos. Then tos+pop -> dout=0x33, count=2. Then tos -> dout=0x22.
- Fill to 4 entries (0xA1..0xA4), then push 0x55 -> full=1, count=4, overflow=1. Pop three times, then tos -> dout=0xA1, with no 0x55 anywhere.
- Empty stack: pop -> underflow=1, count=0. Then tos -> dout unchanged at 0. Then push 0x7E -> count=1, and tos -> dout=0x7E.
- Full stack (top 0xA4), push+pop with din=0x99 -> count=4, overflow=0, and tos -> dout=0x99. push+pop on empty with din=0x42 -> count=1, underflow=1.
- Assert rst asynchronously mid-cycle with count=3 and push pending -> count=0, flags cleared immediately without waiting for clk. After release, a push of 0x10 then tos -> dout=0x10.
